muldiv_hilo: RTL and testbench

MULDIV_HILO -- requirements
Module: muldiv_hilo

---
 rtl/muldiv_hilo.sv | 147 ++++++++++++++
 tb/tb_muldiv_hilo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// ---------------------------------------------------------------------------
// muldiv_hilo
//
// Multi-cycle multiply/divide unit with HI/LO result registers, modelled on
// a classic MIPS-style mult/div block.
//
// An operation is accepted on a rising edge where start=1 and busy=0.
// Operands and opcode are captured on that edge. busy then stays high for
// MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) cycles. HI/LO are
// updated on the edge where busy falls.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   reset      : asynchronous, active-high reset
//   start      : begin an operation (ignored while busy)
//   op         : 00 multu, 01 mult, 10 divu, 11 div
//   we         : direct write of HI/LO (mthi/mtlo); ignored while busy
//                and ignored when start is also asserted
//   hilo_wsel  : write target for we (1 = HI, 0 = LO)
//   rd_sel     : read select (0 = HI, 1 = LO)
//   A          : rs operand, and the write data for we
//   B          : rt operand
//   busy       : operation in progress
//   result     : rd_sel ? LO : HI (combinational from the registers)
//
// Build option
//   MULDIV_DIV0_KEEP_EN : when defined, div/divu with B=0 leaves HI/LO
//                         unchanged. When undefined, div/divu with B=0
//                         writes LO=0xFFFFFFFF and HI=A.
// ---------------------------------------------------------------------------
module muldiv_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        we,
  input  logic        hilo_wsel,
  input  logic        rd_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] result
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [1:0]       op_q, op_d;

  // Arithmetic on the captured operands
  logic        is_signed;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] q_mag, r_mag;
  logic [31:0] quot, rem;
  logic        finish;

  assign busy   = (cnt_q != '0);
  assign finish = (cnt_q == CNT_W'(1));
  assign result = rd_sel ? lo_q : hi_q;

  assign is_signed = op_q[0];

  // Sign-extend (or zero-extend) to 64 bits; the low 64 bits of the
  // product are then correct for both signed and unsigned operands.
  assign prod = {{32{is_signed & a_q[31]}}, a_q} * {{32{is_signed & b_q[31]}}, b_q};

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder follows the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  assign a_neg = is_signed & a_q[31];
  assign b_neg = is_signed & b_q[31];
  assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;

    if (busy) begin
      // start/we are ignored while an operation is in flight
      cnt_d = cnt_q - CNT_W'(1);
      if (finish) begin
        if (!op_q[1]) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (b_q == 32'd0) begin
`ifdef MULDIV_DIV0_KEEP_EN
          hi_d = hi_q;
          lo_d = lo_q;
`else
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
`endif
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
    end else if (start) begin
      // start wins over a simultaneous we
      a_d   = A;
      b_d   = B;
      op_d  = op;
      cnt_d = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (we) begin
      if (hilo_wsel) hi_d = A;
      else           lo_d = A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// ---------------------------------------------------------------------------
// tb_muldiv_hilo
//
// Directed testbench for muldiv_hilo. Inputs change on the falling edge,
// outputs are sampled on the falling edge (away from the active edge).
// Honours MULDIV_DIV0_KEEP_EN for the divide-by-zero expectation.
// ---------------------------------------------------------------------------
module tb_muldiv_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        we;
  logic        hilo_wsel;
  logic        rd_sel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  muldiv_hilo #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .we       (we),
    .hilo_wsel(hilo_wsel),
    .rd_sel   (rd_sel),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reads HI then LO through result (still before the next rising edge).
  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    rd_sel = 1'b0;
    #1;
    check({tag, " HI"}, result, exp_hi);
    rd_sel = 1'b1;
    #1;
    check({tag, " LO"}, result, exp_lo);
  endtask

  // Must be called at a falling edge with busy=0. Returns at the first
  // falling edge where busy=0 again, so consecutive calls are back-to-back.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cycles,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, cnt, exp_cycles);
    check_hilo(tag, exp_hi, exp_lo);
    $display("op %s: op=%0b A=0x%08h B=0x%08h cycles=%0d", tag, o, a, b, cnt);
  endtask

  initial begin
    int cnt;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 2'b00;
    we        = 1'b0;
    hilo_wsel = 1'b0;
    rd_sel    = 1'b0;
    A         = '0;
    B         = '0;

    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check_hilo("reset", 32'd0, 32'd0);
    reset = 1'b0;
    $display("reset released");

    // Start on the very first edge after reset release
    do_op("mult neg*7",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 5,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("multu ff*ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult -1*-1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001);
    do_op("div -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    do_op("divu 100/7",  OP_DIVU,  32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002, 32'h0000_000E);
    do_op("div 7/-2",    OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
`ifdef MULDIV_DIV0_KEEP_EN
    do_op("divu /0",     OP_DIVU,  32'h1234_5678, 32'h0000_0000, 10, 32'h0000_0001, 32'hFFFF_FFFD);
`else
    do_op("divu /0",     OP_DIVU,  32'h1234_5678, 32'h0000_0000, 10, 32'h1234_5678, 32'hFFFF_FFFF);
`endif

    // Direct writes
    we = 1'b1; hilo_wsel = 1'b1; A = 32'h1234_5678;
    @(negedge clk);
    we = 1'b0;
    rd_sel = 1'b0;
    #1;
    check("mthi", result, 32'h1234_5678);
    $display("mthi A=0x12345678");
    @(negedge clk);
    we = 1'b1; hilo_wsel = 1'b0; A = 32'hCAFE_F00D;
    @(negedge clk);
    we = 1'b0;
    check_hilo("mtlo", 32'h1234_5678, 32'hCAFE_F00D);
    $display("mtlo A=0xCAFEF00D");

    // start and we together: start wins, LO is not overwritten with A
    we = 1'b1; hilo_wsel = 1'b0;
    do_op("start+we", OP_DIVU, 32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002, 32'h0000_000E);
    we = 1'b0;

    // start and we while busy are ignored; old HI/LO visible during busy
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; A = 32'h0000_0003; B = 32'h0000_0004;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    @(negedge clk);
    cnt++;
    start = 1'b1; op = OP_DIV; we = 1'b1; hilo_wsel = 1'b1;
    A = 32'hDEAD_BEEF; B = 32'h0000_0001;
    check_hilo("during busy", 32'h0000_0002, 32'h0000_000E);
    @(negedge clk);
    cnt++;
    start = 1'b0; we = 1'b0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("ignored busy cycles", cnt, 32'd5 + 32'd1);
    check_hilo("ignored", 32'h0000_0000, 32'h0000_000C);
    $display("ignored start/we while busy, cycles=%0d", cnt - 1);

    // Reset in busy cycle 3 of a divide
    start = 1'b1; op = OP_DIV; A = 32'hFFFF_FFF9; B = 32'h0000_0002;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy before reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset mid busy", {31'd0, busy}, 32'd0);
    check_hilo("reset mid", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("busy after reset", cnt, 32'd0);
    check_hilo("after reset", 32'd0, 32'd0);
    $display("reset during divide");

    do_op("post-reset mult", OP_MULT, 32'h0000_0006, 32'hFFFF_FFFE, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
